bp_me_io_cmd_arb: RTL and testbench
===================================

Name: bp_me_io_cmd_arb

Overview:
Parametrised N-to-1 arbiter/multiplexer for host-side IO command/response links. It merges N loader channels (cfg loader, nbf loader, register restore, debug agents, ...) onto one io_cmd/io_resp link toward the IO link converter. It generalises two-way fixed-priority muxing with several additions:
- N channels
- selectable fixed-priority or round-robin arbitration
- grant locking under backpressure
- multiple outstanding commands, with in-order response routing through a tag FIFO

Parameters:
num_chan_p, 3, number of upstream requester channels (>=2)
msg_width_p, 128, width of one IO message (command or response), opaque to the block
outstanding_p, 4, maximum commands in flight awaiting response (tag FIFO depth, >=1)
rr_p, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
chan_cmd_i  in  num_chan_p*msg_width_p  per-channel commands, channel i at [i*msg_width_p+:msg_width_p]
chan_cmd_v_i  in  num_chan_p  per-channel command valid
chan_cmd_ready_o  out  num_chan_p  per-channel command ready
chan_resp_o  out  msg_width_p  response data, broadcast to all channels
chan_resp_v_o  out  num_chan_p  one-hot response valid
chan_resp_ready_i  in  num_chan_p  per-channel response ready
io_cmd_o  out  msg_width_p  merged command
io_cmd_v_o  out  1  merged command valid
io_cmd_ready_i  in  1  downstream ready
io_resp_i  in  msg_width_p  downstream response
io_resp_v_i  in  1  downstream response valid
io_resp_ready_o  out  1  downstream response ready
err_o  out  1  sticky error: response received with no command outstanding

Behaviour:
- Handshakes: all links are ready/valid; a transfer occurs on v & ready in the same cycle.
- Command path is combinational, 0 cycles latency.
- Arbitration candidates: chan_cmd_v_i. Fixed mode picks the lowest index. RR mode picks the first valid index at or after rr_ptr_r, wrapping num_chan_p-1 -> 0.
- Outputs: io_cmd_v_o = |candidates & ~fifo_full. io_cmd_o = selected channel's data. chan_cmd_ready_o[i] = grant[i] & io_cmd_ready_i & ~fifo_full; all other ready bits are 0.
- Lock: if io_cmd_v_o=1 and io_cmd_ready_i=0, set lock_r=1 and lock_id_r=grant. While locked, grant is forced to lock_id_r regardless of newly valid higher-priority channels, so io_cmd_o/io_cmd_v_o stay stable. Lock clears on the accepting handshake.
- RR pointer: on an accepted command from channel g, rr_ptr_r <= g+1 mod num_chan_p. The pointer is unchanged in fixed mode and on idle cycles.
- Tag FIFO: depth outstanding_p, entry width clog2(num_chan_p) (min 1). Push the grant id on each accepted command. Full blocks new commands even if a pop occurs in the same cycle. Push and pop in the same cycle when not full are both performed; the count is unchanged.
- Response routing (downstream responses arrive in command order):
  - chan_resp_o = io_resp_i.
  - chan_resp_v_o[head] = io_resp_v_i & ~fifo_empty.
  - io_resp_ready_o = chan_resp_ready_i[head] & ~fifo_empty.
  - Pop on io_resp_v_i & io_resp_ready_o.
- Empty FIFO with io_resp_v_i=1: io_resp_ready_o=0, all chan_resp_v_o=0, err_o set. err_o is cleared only by reset.
- Reset (asynchronous, any cycle including mid-transfer): FIFO emptied, rr_ptr_r=0, lock_r=0, err_o=0. Outputs then read io_cmd_v_o=0, all chan_cmd_ready_o=0, chan_resp_v_o=0, io_resp_ready_o=0. In-flight tags are discarded.
- Sequential state: rr_ptr_r, lock_r, lock_id_r, FIFO pointers and count, err_o.

Optional Feature:
Macro BP_ME_IO_CMD_ARB_STATS_EN.
- Defined: adds output stat_cmd_cnt_o (num_chan_p*32). Per-channel 32-bit counters increment on each accepted command from that channel, wrap at 2^32, and are cleared by reset.
- Also adds output stat_stall_cnt_o (32). It counts cycles with io_cmd_v_o=1 and io_cmd_ready_i=0.
- Undefined: neither port nor the counter logic exists; behaviour is otherwise identical.

Test Plan:
- Fixed mode, N=3, ch0 and ch2 valid, ready=1 -> ch0 granted every cycle, ch2 starved; responses routed to ch0 only.
- RR mode, all 3 valid, ready=1, outstanding_p=8 -> grant order 0,1,2,0,1,2; responses 1..6 returned in order go to 0,1,2,0,1,2.
- Lock: ch2 valid, io_cmd_ready_i=0 for 3 cycles, ch0 becomes valid at cycle 1 -> io_cmd_o stays ch2 data until acceptance at cycle 3, then ch0 is granted.
- Full: outstanding_p=2, issue 2 commands with no responses -> io_cmd_v_o=0 and all ready=0. After one response is popped, the next command is accepted the following cycle.
- Spurious response: io_resp_v_i=1 with FIFO empty -> io_resp_ready_o=0 and err_o=1, persisting until reset_n_i=0.
- Reset mid-lock with 2 tags outstanding -> rr_ptr=0, FIFO empty, err_o=0; a subsequent command from ch1 is granted first in RR mode.

Source files
------------

// File: rtl/bp_me_io_cmd_arb.sv
// rtl/bp_me_io_cmd_arb.sv - N-to-1 IO command arbiter with lock and in-order response routing
// Optional per-channel accept and stall counters under BP_ME_IO_CMD_ARB_STATS_EN.
module bp_me_io_cmd_arb #(
  parameter int num_chan_p    = 3,
  parameter int msg_width_p   = 128,
  parameter int outstanding_p = 4,
  parameter int rr_p          = 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_chan_p*msg_width_p-1:0] chan_cmd_i,
  input  logic [num_chan_p-1:0]             chan_cmd_v_i,
  output logic [num_chan_p-1:0]             chan_cmd_ready_o,
  output logic [msg_width_p-1:0]            chan_resp_o,
  output logic [num_chan_p-1:0]             chan_resp_v_o,
  input  logic [num_chan_p-1:0]             chan_resp_ready_i,
  output logic [msg_width_p-1:0]            io_cmd_o,
  output logic                              io_cmd_v_o,
  input  logic                              io_cmd_ready_i,
  input  logic [msg_width_p-1:0]            io_resp_i,
  input  logic                              io_resp_v_i,
  output logic                              io_resp_ready_o,
  output logic                              err_o
`ifdef BP_ME_IO_CMD_ARB_STATS_EN
  ,
  output logic [num_chan_p*32-1:0]          stat_cmd_cnt_o,
  output logic [31:0]                       stat_stall_cnt_o
`endif
);

  localparam int id_w_lp  = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
  localparam int ptr_w_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(outstanding_p + 1);

  logic [id_w_lp-1:0]  rr_ptr_q, rr_ptr_d;
  logic                lock_q, lock_d;
  logic [id_w_lp-1:0]  lock_id_q, lock_id_d;
  logic [id_w_lp-1:0]  tag_q [outstanding_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                err_q, err_d;

  logic [id_w_lp-1:0]  arb_id;
  logic                arb_found;
  logic [id_w_lp-1:0]  grant_id;
  logic [id_w_lp-1:0]  head_id;
  logic                fifo_full, fifo_empty;
  logic                cmd_fire, resp_fire;

  assign fifo_full  = (count_q == cnt_w_lp'(outstanding_p));
  assign fifo_empty = (count_q == '0);

  // First pass honours the round-robin start point; second pass wraps to index 0.
  always_comb begin
    arb_id    = '0;
    arb_found = 1'b0;
    for (int i = 0; i < num_chan_p; i++) begin
      if (!arb_found && chan_cmd_v_i[i] && ((rr_p == 0) || (i >= int'(rr_ptr_q)))) begin
        arb_found = 1'b1;
        arb_id    = id_w_lp'(i);
      end
    end
    for (int i = 0; i < num_chan_p; i++) begin
      if (!arb_found && chan_cmd_v_i[i]) begin
        arb_found = 1'b1;
        arb_id    = id_w_lp'(i);
      end
    end
  end

  assign grant_id   = lock_q ? lock_id_q : arb_id;
  assign io_cmd_v_o = (|chan_cmd_v_i) & ~fifo_full;
  assign cmd_fire   = io_cmd_v_o & io_cmd_ready_i;

  always_comb begin
    io_cmd_o         = '0;
    chan_cmd_ready_o = '0;
    for (int i = 0; i < num_chan_p; i++) begin
      if (grant_id == id_w_lp'(i)) begin
        io_cmd_o            = chan_cmd_i[i*msg_width_p +: msg_width_p];
        chan_cmd_ready_o[i] = io_cmd_v_o & io_cmd_ready_i;
      end
    end
  end

  assign head_id     = tag_q[rd_ptr_q];
  assign chan_resp_o = io_resp_i;

  always_comb begin
    chan_resp_v_o   = '0;
    io_resp_ready_o = 1'b0;
    for (int i = 0; i < num_chan_p; i++) begin
      if (head_id == id_w_lp'(i)) begin
        chan_resp_v_o[i] = io_resp_v_i & ~fifo_empty;
        io_resp_ready_o  = chan_resp_ready_i[i] & ~fifo_empty;
      end
    end
  end

  assign resp_fire = io_resp_v_i & io_resp_ready_o;

  // Hold the offered command stable while the link backpressures it.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (cmd_fire) begin
      lock_d = 1'b0;
    end else if (io_cmd_v_o && !io_cmd_ready_i) begin
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((rr_p != 0) && cmd_fire) begin
      rr_ptr_d = (grant_id == id_w_lp'(num_chan_p - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (cmd_fire) begin
      wr_ptr_d = (wr_ptr_q == ptr_w_lp'(outstanding_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (resp_fire) begin
      rd_ptr_d = (rd_ptr_q == ptr_w_lp'(outstanding_p - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({cmd_fire, resp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign err_d = err_q | (io_resp_v_i & fifo_empty);
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < outstanding_p; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      if (cmd_fire) begin
        tag_q[wr_ptr_q] <= grant_id;
      end
    end
  end

`ifdef BP_ME_IO_CMD_ARB_STATS_EN
  logic [31:0] stat_cmd_q [num_chan_p];
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_stall_q <= '0;
      for (int i = 0; i < num_chan_p; i++) begin
        stat_cmd_q[i] <= '0;
      end
    end else begin
      if (io_cmd_v_o && !io_cmd_ready_i) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
      for (int i = 0; i < num_chan_p; i++) begin
        if (chan_cmd_ready_o[i]) begin
          stat_cmd_q[i] <= stat_cmd_q[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < num_chan_p; g++) begin : g_stat
    assign stat_cmd_cnt_o[g*32 +: 32] = stat_cmd_q[g];
  end
  assign stat_stall_cnt_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_bp_me_io_cmd_arb.sv
// tb/tb_bp_me_io_cmd_arb.sv - scoreboard bench: fixed-priority (depth 2) and round-robin (depth 4) instances
module tb_bp_me_io_cmd_arb;
  localparam int N = 3;
  localparam int W = 16;

  typedef struct packed {
    logic         inst;
    logic [N-1:0] oh;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*W-1:0] cmd          [2];
  logic [N-1:0]   cmd_v        [2];
  logic [N-1:0]   cmd_rdy      [2];
  logic [W-1:0]   resp_o       [2];
  logic [N-1:0]   resp_v       [2];
  logic [N-1:0]   resp_rdy     [2];
  logic [W-1:0]   io_cmd       [2];
  logic           io_cmd_v     [2];
  logic           io_cmd_ready [2];
  logic [W-1:0]   io_resp      [2];
  logic           io_resp_v    [2];
  logic           io_resp_ready[2];
  logic           err          [2];
`ifdef BP_ME_IO_CMD_ARB_STATS_EN
  logic [N*32-1:0] stat_cmd   [2];
  logic [31:0]     stat_stall [2];
`endif

  exp_t exp_cmd_q[$];
  exp_t exp_rsp_q[$];
  exp_t e_m;
  int checks = 0;
  int errors = 0;

  bp_me_io_cmd_arb #(.num_chan_p(N), .msg_width_p(W), .outstanding_p(2), .rr_p(0)) u_fix (
    .clk_i(clk), .reset_n_i(rst_n),
    .chan_cmd_i(cmd[0]), .chan_cmd_v_i(cmd_v[0]), .chan_cmd_ready_o(cmd_rdy[0]),
    .chan_resp_o(resp_o[0]), .chan_resp_v_o(resp_v[0]), .chan_resp_ready_i(resp_rdy[0]),
    .io_cmd_o(io_cmd[0]), .io_cmd_v_o(io_cmd_v[0]), .io_cmd_ready_i(io_cmd_ready[0]),
    .io_resp_i(io_resp[0]), .io_resp_v_i(io_resp_v[0]), .io_resp_ready_o(io_resp_ready[0]),
    .err_o(err[0])
`ifdef BP_ME_IO_CMD_ARB_STATS_EN
    , .stat_cmd_cnt_o(stat_cmd[0]), .stat_stall_cnt_o(stat_stall[0])
`endif
  );

  bp_me_io_cmd_arb #(.num_chan_p(N), .msg_width_p(W), .outstanding_p(4), .rr_p(1)) u_rr (
    .clk_i(clk), .reset_n_i(rst_n),
    .chan_cmd_i(cmd[1]), .chan_cmd_v_i(cmd_v[1]), .chan_cmd_ready_o(cmd_rdy[1]),
    .chan_resp_o(resp_o[1]), .chan_resp_v_o(resp_v[1]), .chan_resp_ready_i(resp_rdy[1]),
    .io_cmd_o(io_cmd[1]), .io_cmd_v_o(io_cmd_v[1]), .io_cmd_ready_i(io_cmd_ready[1]),
    .io_resp_i(io_resp[1]), .io_resp_v_i(io_resp_v[1]), .io_resp_ready_o(io_resp_ready[1]),
    .err_o(err[1])
`ifdef BP_ME_IO_CMD_ARB_STATS_EN
    , .stat_cmd_cnt_o(stat_cmd[1]), .stat_stall_cnt_o(stat_stall[1])
`endif
  );

  function automatic logic [W-1:0] word(int ch);
    return W'(32'hA000 + ch * 32'h0111);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_cmd(int k, int ch);
    exp_t e;
    e.inst = k[0];
    e.oh   = N'(1 << ch);
    e.data = word(ch);
    exp_cmd_q.push_back(e);
  endtask

  task automatic exp_rsp(int k, int ch, logic [W-1:0] d);
    exp_t e;
    e.inst = k[0];
    e.oh   = N'(1 << ch);
    e.data = d;
    exp_rsp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every accepted command and every routed response against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (io_cmd_v[k] && io_cmd_ready[k]) begin
          if (exp_cmd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cmd_unexpected: inst %0d got %h expected none", k, io_cmd[k]);
          end else begin
            e_m = exp_cmd_q.pop_front();
            chk("cmd_inst", k, e_m.inst);
            chk("cmd_data", io_cmd[k], e_m.data);
            chk("cmd_ready", cmd_rdy[k], e_m.oh);
          end
        end
        if (io_resp_v[k] && io_resp_ready[k]) begin
          if (exp_rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: inst %0d got %h expected none", k, resp_o[k]);
          end else begin
            e_m = exp_rsp_q.pop_front();
            chk("resp_inst", k, e_m.inst);
            chk("resp_data", resp_o[k], e_m.data);
            chk("resp_v", resp_v[k], e_m.oh);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cmd[k]          = {word(2), word(1), word(0)};
      cmd_v[k]        = '0;
      resp_rdy[k]     = '1;
      io_cmd_ready[k] = 1'b1;
      io_resp[k]      = '0;
      io_resp_v[k]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_io_cmd_v", io_cmd_v[k], 0);
      chk("rst_cmd_rdy", cmd_rdy[k], 0);
      chk("rst_resp_v", resp_v[k], 0);
      chk("rst_io_resp_ready", io_resp_ready[k], 0);
      chk("rst_err", err[k], 0);
    end
    rst_n = 1'b1;
    tick();

    // Fixed priority: ch0 wins over ch2, depth-2 FIFO fills
    cmd_v[0] = 3'b101; exp_cmd(0, 0);
    #3 chk("fix_prio_rdy", cmd_rdy[0], 3'b001);
    tick();
    exp_cmd(0, 0); tick();
    io_resp[0] = 16'h0011; io_resp_v[0] = 1'b1; exp_rsp(0, 0, 16'h0011);
    #3 chk("full_io_cmd_v", io_cmd_v[0], 0);
    chk("full_cmd_rdy", cmd_rdy[0], 0);
    tick();
    io_resp_v[0] = 1'b0; exp_cmd(0, 0);
    #3 chk("after_pop_rdy", cmd_rdy[0], 3'b001);
    tick();
    cmd_v[0] = 3'b000; io_resp_v[0] = 1'b1; io_resp[0] = 16'h0012; exp_rsp(0, 0, 16'h0012); tick();
    io_resp[0] = 16'h0013; exp_rsp(0, 0, 16'h0013); tick();
    io_resp_v[0] = 1'b0; cmd_v[0] = 3'b110; exp_cmd(0, 1); tick();
    cmd_v[0] = 3'b000; io_resp_v[0] = 1'b1; io_resp[0] = 16'h0014; exp_rsp(0, 1, 16'h0014); tick();

    // Lock: ch2 held under backpressure while ch0 becomes valid
    io_resp_v[0] = 1'b0; cmd_v[0] = 3'b100; io_cmd_ready[0] = 1'b0;
    #3 chk("lock_v", io_cmd_v[0], 1);
    chk("lock_data0", io_cmd[0], word(2));
    tick();
    cmd_v[0] = 3'b101;
    #3 chk("lock_data1", io_cmd[0], word(2));
    chk("lock_rdy1", cmd_rdy[0], 0);
    tick();
    #3 chk("lock_data2", io_cmd[0], word(2));
    tick();
    io_cmd_ready[0] = 1'b1; exp_cmd(0, 2);
    #3 chk("lock_accept_rdy", cmd_rdy[0], 3'b100);
    tick();
    exp_cmd(0, 0); tick();
    cmd_v[0] = 3'b000; io_resp_v[0] = 1'b1; io_resp[0] = 16'h0021; exp_rsp(0, 2, 16'h0021); tick();
    io_resp[0] = 16'h0022; exp_rsp(0, 0, 16'h0022); tick();

    // Spurious response with empty FIFO
    io_resp[0] = 16'h0099;
    #3 chk("spur_ready", io_resp_ready[0], 0);
    chk("spur_resp_v", resp_v[0], 0);
    tick();
    io_resp_v[0] = 1'b0;
    #3 chk("err_set", err[0], 1);
    tick();

    // Round robin: grant order 0,1,2,0,1,2 with in-order responses
    cmd_v[1] = 3'b111;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        exp_cmd(1, c); tick();
      end
      cmd_v[1] = 3'b000; io_resp_v[1] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        io_resp[1] = W'(r * 3 + c + 1); exp_rsp(1, c, W'(r * 3 + c + 1)); tick();
      end
      io_resp_v[1] = 1'b0; cmd_v[1] = 3'b111;
    end
    cmd_v[1] = 3'b000;

    // Response backpressure from the head channel
    cmd_v[1] = 3'b010; exp_cmd(1, 1); tick();
    cmd_v[1] = 3'b000; io_resp_v[1] = 1'b1; io_resp[1] = 16'h0031; resp_rdy[1] = 3'b101;
    #3 chk("bp_ready", io_resp_ready[1], 0);
    chk("bp_resp_v", resp_v[1], 3'b010);
    tick();
    resp_rdy[1] = 3'b111; exp_rsp(1, 1, 16'h0031); tick();
    io_resp_v[1] = 1'b0;

    // Reset while locked with two tags outstanding
    cmd_v[1] = 3'b001; exp_cmd(1, 0); tick();
    cmd_v[1] = 3'b010; exp_cmd(1, 1); tick();
    cmd_v[1] = 3'b100; io_cmd_ready[1] = 1'b0;
    #3 chk("rr_lock_data", io_cmd[1], word(2));
    tick();
    chk("err_hold", err[0], 1);
    #1 rst_n = 1'b0;
    #1 io_resp_v[1] = 1'b1;
    #1 chk("rst_mid_resp_ready", io_resp_ready[1], 0);
    chk("rst_mid_resp_v", resp_v[1], 0);
    chk("rst_mid_err0", err[0], 0);
    chk("rst_mid_err1", err[1], 0);
    cmd_v[1] = 3'b000; io_resp_v[1] = 1'b0;
    #1 chk("rst_mid_io_cmd_v", io_cmd_v[1], 0);
    tick();
    rst_n = 1'b1;
    tick();
    cmd_v[1] = 3'b110; io_cmd_ready[1] = 1'b1; exp_cmd(1, 1);
    #3 chk("post_rst_grant", io_cmd[1], word(1));
    tick();
    cmd_v[1] = 3'b000; io_resp_v[1] = 1'b1; io_resp[1] = 16'h0041; exp_rsp(1, 1, 16'h0041); tick();
    io_resp_v[1] = 1'b0;
    tick();
    chk("post_rst_err", err[1], 0);
    chk("cmd_q_drained", exp_cmd_q.size(), 0);
    chk("rsp_q_drained", exp_rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
